// File: rtl/max_ccx_pkg.sv
// Shared constants and types for the PCX/CPX word-stream readers.
// Provides PCX packet geometry and the packet reader FSM state type.
package max_ccx_pkg;

    localparam int PCX_PKT_W   = 124;
    localparam int PCX_VLD_BIT = 123;
    localparam int CCX_WORD_W  = 32;
    localparam int PCX_WORDS   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } pcx_rd_state_t;

endpackage

// File: rtl/max_pcx_rd_ctl.sv
// FIFO read-issue control for the PCX packet reader.
// Ports: gclk/arst_l clock and async active-low reset; fifo_empty and
//   fifo_almost_empty from the word FIFO; slot_free when the output slot can
//   take a frame; frame_done on capture of the last word; rd_strobe is the pop
//   strobe; rd_inflight is rd_strobe delayed one cycle (data valid now).
module max_pcx_rd_ctl
    import max_ccx_pkg::*;
#(
    parameter int WORDS_PER_PKT = PCX_WORDS
) (
    input  logic gclk,
    input  logic arst_l,
    input  logic fifo_empty,
    input  logic fifo_almost_empty,
    input  logic slot_free,
    input  logic frame_done,
    output logic rd_strobe,
    output logic rd_inflight
);

    localparam int IW = $clog2(WORDS_PER_PKT + 1);

    logic [IW-1:0] words_issued;
    logic          can_issue;

    // The final word of a frame is held back until the output slot can
    // take the completed packet.
    assign can_issue = (words_issued < IW'(WORDS_PER_PKT - 1)) ||
                       ((words_issued == IW'(WORDS_PER_PKT - 1)) && slot_free);

    // A pop already in flight may have drained the last word.
    assign rd_strobe = !fifo_empty &&
                       !(fifo_almost_empty && rd_inflight) &&
                       can_issue;

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            words_issued <= '0;
            rd_inflight  <= 1'b0;
        end else begin
            rd_inflight <= rd_strobe;
            if (frame_done)
                words_issued <= rd_strobe ? IW'(1) : '0;
            else if (rd_strobe)
                words_issued <= words_issued + IW'(1);
        end
    end

endmodule

// File: rtl/max_pcx_pkt_reader.sv
// Reassembles 4-word PCX frames from the max_pcx FIFO into 124-bit packets.
// Ports: gclk, arst_l (async active-low); max_pcx_empty/almost_empty/data in,
//   max_pcx_read out; pcx_pkt/pcx_pkt_vld out with pcx_pkt_rdy in.
//   With MAX_PCX_STATS_EN defined, pcx_pkt_cnt and pcx_drop_cnt are added.
module max_pcx_pkt_reader
    import max_ccx_pkg::*;
#(
    parameter int WORDS_PER_PKT = PCX_WORDS,
    parameter int PKT_W         = PCX_PKT_W
`ifdef MAX_PCX_STATS_EN
    ,
    parameter int CNT_W         = 16
`endif
) (
    input  logic                  gclk,
    input  logic                  arst_l,
    input  logic                  max_pcx_empty,
    input  logic                  max_pcx_almost_empty,
    input  logic [CCX_WORD_W-1:0] max_pcx_data,
    output logic                  max_pcx_read,
    output logic [PKT_W-1:0]      pcx_pkt,
    output logic                  pcx_pkt_vld,
    input  logic                  pcx_pkt_rdy
`ifdef MAX_PCX_STATS_EN
    ,
    output logic [CNT_W-1:0]      pcx_pkt_cnt,
    output logic [CNT_W-1:0]      pcx_drop_cnt
`endif
);

    // Word 0 keeps only the bits below the pad nibble.
    localparam int W0_W = PCX_PKT_W - 3 * CCX_WORD_W;

    pcx_rd_state_t         state;
    logic                  rd_inflight;
    logic [1:0]            idx;
    logic [W0_W-1:0]       w0;
    logic [CCX_WORD_W-1:0] w1;
    logic [CCX_WORD_W-1:0] w2;
    logic [PCX_PKT_W-1:0]  frame;
    logic                  last_cap;
    logic                  frame_ok;
    logic                  accept;
    logic                  slot_free;
    logic                  busy;

    assign accept    = pcx_pkt_vld && pcx_pkt_rdy;
    assign slot_free = !pcx_pkt_vld || pcx_pkt_rdy;
    assign last_cap  = rd_inflight && (idx == 2'(WORDS_PER_PKT - 1));
    // The last word is taken straight off the FIFO data bus.
    assign frame     = {w0, w1, w2, max_pcx_data};
    assign frame_ok  = frame[PCX_VLD_BIT];
    assign busy      = max_pcx_read || rd_inflight || (idx != 2'd0);

    max_pcx_rd_ctl #(
        .WORDS_PER_PKT(WORDS_PER_PKT)
    ) u_rd_ctl (
        .gclk             (gclk),
        .arst_l           (arst_l),
        .fifo_empty       (max_pcx_empty),
        .fifo_almost_empty(max_pcx_almost_empty),
        .slot_free        (slot_free),
        .frame_done       (last_cap),
        .rd_strobe        (max_pcx_read),
        .rd_inflight      (rd_inflight)
    );

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state       <= IDLE;
            idx         <= 2'd0;
            w0          <= '0;
            w1          <= '0;
            w2          <= '0;
            pcx_pkt     <= '0;
            pcx_pkt_vld <= 1'b0;
        end else begin
            if (rd_inflight) begin
                unique case (idx)
                    2'd0: w0 <= max_pcx_data[W0_W-1:0];
                    2'd1: w1 <= max_pcx_data;
                    2'd2: w2 <= max_pcx_data;
                    2'd3: ;
                endcase
                idx <= idx + 2'd1;
            end

            // A new packet wins over clearing vld on an accept.
            if (last_cap && frame_ok) begin
                pcx_pkt     <= frame;
                pcx_pkt_vld <= 1'b1;
            end else if (accept) begin
                pcx_pkt_vld <= 1'b0;
            end

            unique case (state)
                IDLE:
                    if (busy)
                        state <= COLLECT;
                COLLECT:
                    if (last_cap)
                        state <= frame_ok ? HOLD : IDLE;
                HOLD:
                    if (accept && !(last_cap && frame_ok))
                        state <= busy ? COLLECT : IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

`ifdef MAX_PCX_STATS_EN
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            pcx_pkt_cnt  <= '0;
            pcx_drop_cnt <= '0;
        end else begin
            if (accept && (pcx_pkt_cnt != '1))
                pcx_pkt_cnt <= pcx_pkt_cnt + 1'b1;
            if (last_cap && !frame_ok && (pcx_drop_cnt != '1))
                pcx_drop_cnt <= pcx_drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_max_pcx_pkt_reader.sv
// Directed bench for max_pcx_pkt_reader with a behavioural word FIFO.
// Table vectors plus hand sequences for hold, throttle, drop and reset cases.
module tb_max_pcx_pkt_reader;
    import max_ccx_pkg::*;

    typedef struct {
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [31:0]  w2;
        logic [31:0]  w3;
        bit           exp_vld;
        logic [123:0] exp_pkt;
    } vec_t;

    logic         gclk = 1'b0;
    logic         arst_l = 1'b0;
    logic         max_pcx_empty = 1'b1;
    logic         max_pcx_almost_empty = 1'b1;
    logic [31:0]  max_pcx_data = '0;
    logic         max_pcx_read;
    logic [123:0] pcx_pkt;
    logic         pcx_pkt_vld;
    logic         pcx_pkt_rdy = 1'b1;
`ifdef MAX_PCX_STATS_EN
    logic [15:0]  pcx_pkt_cnt;
    logic [15:0]  pcx_drop_cnt;
`endif

    max_pcx_pkt_reader dut (
        .gclk                (gclk),
        .arst_l              (arst_l),
        .max_pcx_empty       (max_pcx_empty),
        .max_pcx_almost_empty(max_pcx_almost_empty),
        .max_pcx_data        (max_pcx_data),
        .max_pcx_read        (max_pcx_read),
        .pcx_pkt             (pcx_pkt),
        .pcx_pkt_vld         (pcx_pkt_vld),
        .pcx_pkt_rdy         (pcx_pkt_rdy)
`ifdef MAX_PCX_STATS_EN
        ,
        .pcx_pkt_cnt         (pcx_pkt_cnt),
        .pcx_drop_cnt        (pcx_drop_cnt)
`endif
    );

    always #5 gclk = ~gclk;

    logic [31:0]  q[$];
    logic [123:0] acc_q[$];
    logic         push_stb = 1'b0;
    logic [31:0]  push_word = '0;
    logic         prev_rd = 1'b0;
    logic         vld_q = 1'b0;
    int           overread = 0;
    int           ae_viol = 0;
    int           rd_cnt = 0;
    int           vld_hi = 0;
    int           cyc = 0;
    int           last_rd_cyc = 0;
    int           vld_rise_cyc = 0;
    int           n_chk = 0;
    int           n_pass = 0;

    // Word FIFO: pop on a sampled read, data shows up the following cycle.
    always @(posedge gclk) begin
        cyc <= cyc + 1;
        if (max_pcx_read) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
            if (max_pcx_empty || q.size() == 0)
                overread <= overread + 1;
            else
                max_pcx_data <= q.pop_front();
            if (max_pcx_almost_empty && prev_rd)
                ae_viol <= ae_viol + 1;
        end
        prev_rd <= max_pcx_read;
        if (push_stb)
            q.push_back(push_word);
        max_pcx_empty        <= (q.size() == 0);
        max_pcx_almost_empty <= (q.size() <= 1);
        if (pcx_pkt_vld)
            vld_hi <= vld_hi + 1;
        if (pcx_pkt_vld && !vld_q)
            vld_rise_cyc <= cyc;
        vld_q <= pcx_pkt_vld;
        if (pcx_pkt_vld && pcx_pkt_rdy)
            acc_q.push_back(pcx_pkt);
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] w);
        push_word = w;
        push_stb  = 1'b1;
        @(negedge gclk);
        push_stb  = 1'b0;
    endtask

    task automatic push4(input vec_t v);
        push(v.w0);
        push(v.w1);
        push(v.w2);
        push(v.w3);
    endtask

    task automatic do_reset();
        arst_l = 1'b0;
        repeat (2) @(negedge gclk);
        arst_l = 1'b1;
        @(negedge gclk);
    endtask

    vec_t         vecs[6];
    vec_t         fv;
    int           base;
    int           rd0;
    int           vh0;
    int           stat_base;
    logic [123:0] exp6[16];

    initial begin
        vecs[0] = '{32'h8801_7000, 32'h0000_0000, 32'h0001_0001, 32'h0000_0002,
                    1'b1, 124'h801_7000_0000_0000_0001_0001_0000_0002};
        vecs[1] = '{32'h0000_1234, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                    1'b0, 124'h0};
        vecs[2] = '{32'h0800_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                    1'b1, 124'h800_0000_0000_0000_0000_0000_0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    1'b1, 124'hFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{32'h7000_0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678,
                    1'b0, 124'h0};
        vecs[5] = '{32'h0ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F,
                    1'b1, 124'hABC_DEF0_1234_5678_9ABC_DEF0_0F0F_0F0F};

        // Reset state
        repeat (2) @(negedge gclk);
        chk("rst_vld", pcx_pkt_vld, 0);
        chk("rst_pkt", pcx_pkt, 0);
        chk("rst_read", max_pcx_read, 0);
`ifdef MAX_PCX_STATS_EN
        chk("rst_pkt_cnt", pcx_pkt_cnt, 0);
        chk("rst_drop_cnt", pcx_drop_cnt, 0);
`endif
        arst_l = 1'b1;
        @(negedge gclk);
        stat_base = acc_q.size();

        // Test 1: single frame, rdy=1, latency and one-cycle vld
        pcx_pkt_rdy = 1'b1;
        base = acc_q.size();
        vh0  = vld_hi;
        push4(vecs[0]);
        repeat (12) @(negedge gclk);
        chk("t1_count", acc_q.size() - base, 1);
        if (acc_q.size() > base)
            chk("t1_pkt", acc_q[base], vecs[0].exp_pkt);
        chk("t1_vld_cycles", vld_hi - vh0, 1);
        chk("t1_latency", vld_rise_cyc - last_rd_cyc, 2);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            base = acc_q.size();
            push4(vecs[i]);
            repeat (12) @(negedge gclk);
            chk($sformatf("vec%0d_count", i), acc_q.size() - base,
                vecs[i].exp_vld ? 1 : 0);
            if (vecs[i].exp_vld && acc_q.size() > base)
                chk($sformatf("vec%0d_pkt", i), acc_q[base], vecs[i].exp_pkt);
        end
`ifdef MAX_PCX_STATS_EN
        chk("tbl_drop_cnt", pcx_drop_cnt, 2);
`endif

        // Test 2: held output, only three reads of the next frame
        pcx_pkt_rdy = 1'b0;
        base = acc_q.size();
        push4(vecs[0]);
        for (int k = 0; k < 20 && !pcx_pkt_vld; k++)
            @(negedge gclk);
        chk("t2_vld_up", pcx_pkt_vld, 1);
        rd0 = rd_cnt;
        push4(vecs[5]);
        for (int k = 0; k < 10; k++) begin
            @(negedge gclk);
            chk($sformatf("t2_hold_vld%0d", k), pcx_pkt_vld, 1);
            chk($sformatf("t2_hold_pkt%0d", k), pcx_pkt, vecs[0].exp_pkt);
        end
        chk("t2_reads_held", rd_cnt - rd0, 3);
        chk("t2_no_accept", acc_q.size() - base, 0);
        pcx_pkt_rdy = 1'b1;
        repeat (12) @(negedge gclk);
        chk("t2_reads_total", rd_cnt - rd0, 4);
        chk("t2_count", acc_q.size() - base, 2);
        if (acc_q.size() > base + 1) begin
            chk("t2_pkt_a", acc_q[base], vecs[0].exp_pkt);
            chk("t2_pkt_b", acc_q[base+1], vecs[5].exp_pkt);
        end

        // Test 3: single-word FIFO, no read until more data arrives
        base = acc_q.size();
        rd0  = rd_cnt;
        push(32'h0800_0000);
        repeat (8) @(negedge gclk);
        chk("t3_one_read", rd_cnt - rd0, 1);
        chk("t3_read_idle", max_pcx_read, 0);
        for (int k = 0; k < 3; k++) begin
            push(32'h0000_0000);
            repeat (3) @(negedge gclk);
        end
        repeat (6) @(negedge gclk);
        chk("t3_reads", rd_cnt - rd0, 4);
        chk("t3_count", acc_q.size() - base, 1);
        if (acc_q.size() > base)
            chk("t3_pkt", acc_q[base], vecs[2].exp_pkt);

        // Test 4: dropped frame followed by a valid one
        base = acc_q.size();
        push4(vecs[1]);
        push4(vecs[5]);
        repeat (14) @(negedge gclk);
        chk("t4_count", acc_q.size() - base, 1);
        if (acc_q.size() > base)
            chk("t4_pkt", acc_q[base], vecs[5].exp_pkt);
`ifdef MAX_PCX_STATS_EN
        chk("t4_drop_cnt", pcx_drop_cnt, 3);
        chk("t4_pkt_cnt", pcx_pkt_cnt, acc_q.size() - stat_base);
`endif

        // Test 5: reset after two captured words discards them
        push(32'h0FFF_FFFF);
        push(32'hFFFF_FFFF);
        repeat (6) @(negedge gclk);
        arst_l = 1'b0;
        @(negedge gclk);
        chk("t5_rst_vld", pcx_pkt_vld, 0);
        chk("t5_rst_pkt", pcx_pkt, 0);
        @(negedge gclk);
        arst_l = 1'b1;
        @(negedge gclk);
        stat_base = acc_q.size();
        base = acc_q.size();
        push4(vecs[5]);
        repeat (12) @(negedge gclk);
        chk("t5_count", acc_q.size() - base, 1);
        if (acc_q.size() > base)
            chk("t5_pkt", acc_q[base], vecs[5].exp_pkt);

        // Test 6: 16 back-to-back frames with rdy toggling
        do_reset();
        base = acc_q.size();
        for (int f = 0; f < 16; f++) begin
            logic [31:0] fi;
            fi = 32'(f);
            fv.w0 = {fi[3:0], 28'h800_0000 | {12'h0, fi[15:0]}};
            fv.w1 = 32'hA5A5_0000 | fi;
            fv.w2 = ~fi;
            fv.w3 = fi * 32'h0101_0101;
            exp6[f] = {fv.w0[27:0], fv.w1, fv.w2, fv.w3};
        end
        fork
            for (int f = 0; f < 16; f++) begin
                logic [31:0] fi;
                vec_t        pv;
                fi = 32'(f);
                pv.w0 = {fi[3:0], 28'h800_0000 | {12'h0, fi[15:0]}};
                pv.w1 = 32'hA5A5_0000 | fi;
                pv.w2 = ~fi;
                pv.w3 = fi * 32'h0101_0101;
                pv.exp_vld = 1'b1;
                pv.exp_pkt = '0;
                push4(pv);
            end
            for (int k = 0; k < 160; k++) begin
                pcx_pkt_rdy = k[0];
                @(negedge gclk);
            end
        join
        pcx_pkt_rdy = 1'b1;
        for (int k = 0; k < 400 && acc_q.size() < base + 16; k++)
            @(negedge gclk);
        chk("t6_count", acc_q.size() - base, 16);
        for (int f = 0; f < 16; f++)
            if (acc_q.size() > base + f)
                chk($sformatf("t6_pkt%0d", f), acc_q[base+f], exp6[f]);
`ifdef MAX_PCX_STATS_EN
        chk("t6_pkt_cnt", pcx_pkt_cnt, 16);
        chk("t6_drop_cnt", pcx_drop_cnt, 0);
`endif

        chk("no_overread", overread, 0);
        chk("ae_throttle", ae_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
